// File: rtl/tick_sched_pkg.sv
// Shared definitions for tick_scheduler: command opcodes, command FSM states
// and the default prescaler ratio.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_START = 2'b10,
    OP_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cmd_state_e;

  // 100 MHz system clock divided down to a 1 kHz base tick.
  localparam int DEFAULT_PRESCALE = 100000;

endpackage

// File: rtl/tick_channel.sv
// One programmable timebase channel: period register, countdown, mode and
// running flag, advanced by the shared base tick.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] load_data,
  input  logic                oneshot,
  input  logic                base_tick,
  output logic                tick,
  output logic                running
);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic                oneshot_q, oneshot_d;
  logic                running_q, running_d;
  logic                expire;

  // A START or STOP landing on the expiry base tick takes priority and
  // suppresses that tick; a LOAD only changes what the next reload uses.
  always_comb begin
    expire    = base_tick && running_q && (count_q == '0) && !start && !stop;
    period_d  = period_q;
    count_d   = count_q;
    oneshot_d = oneshot_q;
    running_d = running_q;

    if (load) begin
      period_d = (load_data == '0) ? PERIOD_W'(1) : load_data;
    end

    if (start) begin
      count_d   = period_q - PERIOD_W'(1);
      oneshot_d = oneshot;
      running_d = 1'b1;
    end else if (stop) begin
      running_d = 1'b0;
    end else if (base_tick && running_q) begin
      if (count_q == '0) begin
        if (oneshot_q) begin
          running_d = 1'b0;
        end else begin
          count_d = period_q - PERIOD_W'(1);
        end
      end else begin
        count_d = count_q - PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q  <= PERIOD_W'(1);
      count_q   <= '0;
      oneshot_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      count_q   <= count_d;
      oneshot_q <= oneshot_d;
      running_q <= running_d;
    end
  end

  assign tick    = expire;
  assign running = running_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler plus NUM_CH programmable tick channels behind a
// valid/ready command port. Optional TICK_SCHED_BYPASS_EN adds a Bypass input.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16,
  parameter int CH_W     = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Cmd_Valid,
  output logic                Cmd_Ready,
  input  logic [1:0]          Cmd_Op,
  input  logic [CH_W-1:0]     Cmd_Ch,
  input  logic [PERIOD_W-1:0] Cmd_Data,
  input  logic                Cmd_Oneshot,
  output logic                Cmd_Err,
  output logic                Base_Tick,
  output logic [NUM_CH-1:0]   Tick_Out,
  output logic [NUM_CH-1:0]   Running
`ifdef TICK_SCHED_BYPASS_EN
  ,
  input  logic                Bypass
`endif
);

  localparam int              PS_W       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [CH_W:0]   NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

  logic                bypass;
  logic [PS_W-1:0]     ps_count_q, ps_count_d;
  logic                ps_wrap;

  cmd_state_e          state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                cmd_err_q, cmd_err_d;
  cmd_op_e             op_q, op_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [PERIOD_W-1:0] data_q, data_d;
  logic                oneshot_q, oneshot_d;
  logic                accept;
  logic                ch_invalid;
  logic                apply;

`ifdef TICK_SCHED_BYPASS_EN
  assign bypass = Bypass;
`else
  assign bypass = 1'b0;
`endif

  // Free-running prescaler; bypass parks it at 0 and strobes every cycle.
  always_comb begin
    ps_wrap = (ps_count_q == PS_LAST);
    if (bypass || ps_wrap) begin
      ps_count_d = '0;
    end else begin
      ps_count_d = ps_count_q + PS_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ps_count_q <= '0;
    end else begin
      ps_count_q <= ps_count_d;
    end
  end

  assign Base_Tick = bypass || ps_wrap;

  // Command port accepts in IDLE and spends exactly one APPLY cycle per command.
  always_comb begin
    accept      = Cmd_Valid && cmd_ready_q;
    ch_invalid  = ({1'b0, Cmd_Ch} >= NUM_CH_EXT);
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cmd_err_d   = 1'b0;
    op_d        = op_q;
    ch_d        = ch_q;
    data_d      = data_q;
    oneshot_d   = oneshot_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          state_d     = ST_APPLY;
          cmd_ready_d = 1'b0;
          cmd_err_d   = ch_invalid;
          op_d        = cmd_op_e'(Cmd_Op);
          ch_d        = Cmd_Ch;
          data_d      = Cmd_Data;
          oneshot_d   = Cmd_Oneshot;
        end
      end
      ST_APPLY: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      op_q        <= OP_NOP;
      ch_q        <= '0;
      data_q      <= '0;
      oneshot_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      op_q        <= op_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      oneshot_q   <= oneshot_d;
    end
  end

  assign Cmd_Ready = cmd_ready_q;
  assign Cmd_Err   = cmd_err_q;
  assign apply     = (state_q == ST_APPLY);

  // An out-of-range channel matches no instance, so it changes no state.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    logic ch_load;
    logic ch_start;
    logic ch_stop;

    assign sel      = apply && (ch_q == CH_W'(i));
    assign ch_load  = sel && (op_q == OP_LOAD);
    assign ch_start = sel && (op_q == OP_START);
    assign ch_stop  = sel && (op_q == OP_STOP);

    tick_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_channel (
      .clk       (Clk),
      .reset     (Reset),
      .load      (ch_load),
      .start     (ch_start),
      .stop      (ch_stop),
      .load_data (data_q),
      .oneshot   (oneshot_q),
      .base_tick (Base_Tick),
      .tick      (Tick_Out[i]),
      .running   (Running[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler with PRESCALE=4, NUM_CH=4.
// A negedge monitor indexes base ticks and logs per-channel ticks against them.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int PRESCALE = 4;
  localparam int NUM_CH   = 4;
  localparam int PERIOD_W = 16;
  localparam int CH_W     = 4;

  logic                Clk = 1'b0;
  logic                Reset = 1'b1;
  logic                Cmd_Valid = 1'b0;
  logic                Cmd_Ready;
  logic [1:0]          Cmd_Op = 2'b00;
  logic [CH_W-1:0]     Cmd_Ch = '0;
  logic [PERIOD_W-1:0] Cmd_Data = '0;
  logic                Cmd_Oneshot = 1'b0;
  logic                Cmd_Err;
  logic                Base_Tick;
  logic [NUM_CH-1:0]   Tick_Out;
  logic [NUM_CH-1:0]   Running;

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int bt_idx = 0;
  int last_bt_cyc = -1;
  int bt_spacing_err = 0;
  int tick_n [NUM_CH];
  int tick_bt [NUM_CH][64];
  int fall_bt [NUM_CH];
  logic [NUM_CH-1:0] prev_run = '0;

  tick_scheduler #(
    .PRESCALE (PRESCALE),
    .NUM_CH   (NUM_CH),
    .PERIOD_W (PERIOD_W),
    .CH_W     (CH_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Cmd_Valid   (Cmd_Valid),
    .Cmd_Ready   (Cmd_Ready),
    .Cmd_Op      (Cmd_Op),
    .Cmd_Ch      (Cmd_Ch),
    .Cmd_Data    (Cmd_Data),
    .Cmd_Oneshot (Cmd_Oneshot),
    .Cmd_Err     (Cmd_Err),
    .Base_Tick   (Base_Tick),
    .Tick_Out    (Tick_Out),
    .Running     (Running)
`ifdef TICK_SCHED_BYPASS_EN
    ,
    .Bypass      (1'b0)
`endif
  );

  always #5 Clk = ~Clk;

  // Base ticks must stay exactly PRESCALE cycles apart outside reset.
  always @(negedge Clk) begin
    cyc++;
    if (Reset) begin
      last_bt_cyc = -1;
    end else if (Base_Tick) begin
      if (last_bt_cyc >= 0 && (cyc - last_bt_cyc) != PRESCALE) bt_spacing_err++;
      last_bt_cyc = cyc;
      bt_idx++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (Tick_Out[c] && tick_n[c] < 64) begin
        tick_bt[c][tick_n[c]] = bt_idx;
        tick_n[c]++;
      end
      if (prev_run[c] && !Running[c]) fall_bt[c] = bt_idx;
    end
    prev_run = Running;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle;
    @(negedge Clk);
    #1;
  endtask

  // Waits for Cmd_Ready, presents one command and returns in its APPLY cycle.
  task automatic applyStimulus(input logic [1:0] op, input int ch, input int data,
                               input logic oneshot);
    int guard = 0;
    while (!Cmd_Ready && guard < 20) begin
      nextCycle();
      guard++;
    end
    checkOutput("cmd_ready_wait", int'(Cmd_Ready), 1);
    Cmd_Valid   = 1'b1;
    Cmd_Op      = op;
    Cmd_Ch      = CH_W'(ch);
    Cmd_Data    = PERIOD_W'(data);
    Cmd_Oneshot = oneshot;
    nextCycle();
    Cmd_Valid   = 1'b0;
    Cmd_Op      = 2'b00;
    Cmd_Oneshot = 1'b0;
  endtask

  task automatic waitBaseTicks(input int target);
    int guard = 0;
    while (bt_idx < target && guard < 2000) begin
      nextCycle();
      guard++;
    end
    checkOutput("bt_reached", int'(bt_idx >= target), 1);
  endtask

  initial begin
    int a;
    int a0;
    int b;
    int e;
    int e_cyc;
    int guard;
    logic [7:0] hist;

    for (int i = 0; i < NUM_CH; i++) begin
      tick_n[i]  = 0;
      fall_bt[i] = -1;
    end

    repeat (3) nextCycle();
    checkOutput("rst_ready", int'(Cmd_Ready), 0);
    checkOutput("rst_err", int'(Cmd_Err), 0);
    checkOutput("rst_base_tick", int'(Base_Tick), 0);
    checkOutput("rst_tick_out", int'(Tick_Out), 0);
    checkOutput("rst_running", int'(Running), 0);
    Reset = 1'b0;

    hist = '0;
    for (int i = 0; i < 8; i++) begin
      hist[i] = Base_Tick;
      if (i == 1) checkOutput("ready_after_rst", int'(Cmd_Ready), 1);
      if (i < 7) nextCycle();
    end
    checkOutput("base_tick_pattern", int'(hist), 8'h88);

    // Periodic channel 0 with period 3.
    applyStimulus(OP_LOAD, 0, 3, 1'b0);
    tick_n[0] = 0;
    applyStimulus(OP_START, 0, 0, 1'b0);
    a0 = bt_idx;
    waitBaseTicks(a0 + 9);
    checkOutput("per_count", tick_n[0], 3);
    checkOutput("per_first", tick_bt[0][0], a0 + 3);
    checkOutput("per_second", tick_bt[0][1], a0 + 6);
    checkOutput("per_third", tick_bt[0][2], a0 + 9);
    checkOutput("per_running", int'(Running[0]), 1);

    // One-shot channel 1 with period 2.
    applyStimulus(OP_LOAD, 1, 2, 1'b0);
    tick_n[1] = 0;
    applyStimulus(OP_START, 1, 0, 1'b1);
    a = bt_idx;
    waitBaseTicks(a + 22);
    checkOutput("os_count", tick_n[1], 1);
    checkOutput("os_at", tick_bt[1][0], a + 2);
    checkOutput("os_fall", fall_bt[1], a + 2);
    checkOutput("os_running", int'(Running[1]), 0);

    // Period 0 behaves as 1, then a live reload to 5.
    applyStimulus(OP_LOAD, 2, 0, 1'b0);
    tick_n[2] = 0;
    applyStimulus(OP_START, 2, 0, 1'b0);
    a = bt_idx;
    waitBaseTicks(a + 3);
    checkOutput("p0_count", tick_n[2], 3);
    checkOutput("p0_first", tick_bt[2][0], a + 1);
    checkOutput("p0_third", tick_bt[2][2], a + 3);
    applyStimulus(OP_LOAD, 2, 5, 1'b0);
    b = bt_idx;
    tick_n[2] = 0;
    waitBaseTicks(b + 11);
    checkOutput("reload_count", tick_n[2], 3);
    checkOutput("reload_first", tick_bt[2][0], b + 1);
    checkOutput("reload_second", tick_bt[2][1], b + 6);
    checkOutput("reload_third", tick_bt[2][2], b + 11);
    applyStimulus(OP_STOP, 2, 0, 1'b0);
    nextCycle();
    checkOutput("stop_running", int'(Running), 4'b0001);

    // Invalid channel and back-to-back handshake.
    applyStimulus(OP_START, 7, 0, 1'b0);
    checkOutput("err_pulse", int'(Cmd_Err), 1);
    checkOutput("err_ready_low", int'(Cmd_Ready), 0);
    nextCycle();
    checkOutput("err_clear", int'(Cmd_Err), 0);
    checkOutput("err_running", int'(Running), 4'b0001);
    Cmd_Valid = 1'b1;
    Cmd_Op    = OP_NOP;
    Cmd_Ch    = '0;
    hist      = '0;
    for (int i = 0; i < 8; i++) begin
      hist[i] = Cmd_Ready;
      nextCycle();
    end
    Cmd_Valid = 1'b0;
    checkOutput("hold_ready_pattern", int'(hist), 8'h55);
    nextCycle();

    // STOP whose APPLY lands exactly on channel 0's expiry base tick.
    e     = a0 + 3 * ((bt_idx - a0) / 3 + 1);
    e_cyc = last_bt_cyc + PRESCALE * (e - bt_idx);
    while (e_cyc - 1 < cyc + 2) begin
      e     += 3;
      e_cyc += 3 * PRESCALE;
    end
    guard = 0;
    while (cyc < e_cyc - 1 && guard < 200) begin
      nextCycle();
      guard++;
    end
    tick_n[0] = 0;
    applyStimulus(OP_STOP, 0, 0, 1'b0);
    checkOutput("coll_base_tick", int'(Base_Tick), 1);
    checkOutput("coll_no_tick", int'(Tick_Out[0]), 0);
    nextCycle();
    checkOutput("coll_running", int'(Running[0]), 0);
    waitBaseTicks(bt_idx + 10);
    checkOutput("coll_silent", tick_n[0], 0);

    // Reset with three channels running, then restart at default period.
    applyStimulus(OP_START, 0, 0, 1'b0);
    applyStimulus(OP_START, 1, 0, 1'b0);
    applyStimulus(OP_START, 2, 0, 1'b0);
    nextCycle();
    checkOutput("three_running", int'(Running), 4'b0111);
    Reset = 1'b1;
    nextCycle();
    Reset = 1'b0;
    checkOutput("mid_rst_tick_out", int'(Tick_Out), 0);
    checkOutput("mid_rst_running", int'(Running), 0);
    checkOutput("mid_rst_base_tick", int'(Base_Tick), 0);
    checkOutput("mid_rst_ready", int'(Cmd_Ready), 0);
    checkOutput("mid_rst_err", int'(Cmd_Err), 0);
    tick_n[0] = 0;
    applyStimulus(OP_START, 0, 0, 1'b0);
    a = bt_idx;
    waitBaseTicks(a + 3);
    checkOutput("post_rst_count", tick_n[0], 3);
    checkOutput("post_rst_first", tick_bt[0][0], a + 1);
    checkOutput("post_rst_third", tick_bt[0][2], a + 3);

    checkOutput("bt_spacing", bt_spacing_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
